// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Handles signed (DIV) and unsigned (DIVU) operation with a start/busy/done handshake.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Datapath state: partial remainder, dividend/quotient shift register, divisor magnitude
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;

    // Registered outputs
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dz_q, dz_d;

    // Combinational helpers
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign divisor_zero = (divisor_i == '0);
    assign dividend_abs = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + WIDTH'(1)) : dividend_i;
    assign divisor_abs  = (signed_i && divisor_i[WIDTH-1])  ? (~divisor_i + WIDTH'(1))  : divisor_i;
    // Trial subtraction is one bit wider so its MSB acts as the borrow/sign
    assign shifted      = {rem_q, dvd_q[WIDTH-1]};
    assign trial        = shifted - {1'b0, dsr_q};

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = divisor_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dz_d    = dz_q;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_FIX);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (divisor_zero) begin
                        // Keep the raw dividend so it can be returned unmodified
                        zero_d = 1'b1;
                        dvd_d  = dividend_i;
                    end else begin
                        zero_d  = 1'b0;
                        dvd_d   = dividend_abs;
                        dsr_d   = divisor_abs;
                        rem_d   = '0;
                        q_neg_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_neg_d = signed_i & dividend_i[WIDTH-1];
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            S_CALC: begin
                // Quotient bits shift in from the right as dividend bits shift out
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    remd_d = dvd_q;
                    dz_d   = 1'b1;
                end else begin
                    quot_d = q_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
                    remd_d = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
                    dz_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = remd_q;
    assign div_zero_o  = dz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit integer divider for the project CPU datapath. It runs in the opposite direction of the ALU adder path: it computes quotient and remainder by restoring (repeated-subtract) division, one quotient bit per clock. The block sits beside the ALU and serves DIV/DIVU with a start/busy/done handshake. Control stalls the pipeline while `busy_o` is high.

## Interface
- `WIDTH`, 32, operand/result width (tests use 32)
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  request; sampled only in IDLE
- `signed_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- `dividend_i`  in  WIDTH  dividend; sampled with start
- `divisor_i`  in  WIDTH  divisor; sampled with start
- `busy_o`  out  1  operation in progress
- `done_o`  out  1  one-cycle pulse; results valid
- `quotient_o`  out  WIDTH  registered quotient
- `remainder_o`  out  WIDTH  registered remainder
- `div_zero_o`  out  1  last completed operation had divisor == 0

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - If `start_i` is 1 and divisor ≠ 0: latch operand magnitudes (two's-complement abs when `signed_i`=1 and operand MSB=1), latch sign flags, clear partial remainder, load iteration counter = WIDTH, go to CALC.
  - If `start_i` is 1 and divisor = 0: set the div-zero flag and go straight to FIX.
- CALC, one iteration per cycle:
  - Shift {rem, dvd} left 1.
  - Trial = rem − divisor (WIDTH+1 bits).
  - If trial is non-negative: rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - Decrement the counter. After the WIDTH-th iteration, go to FIX.
- FIX:
  - Register the results.
  - Quotient is negated if `signed_i` is set and the operand signs differ.
  - Remainder takes the sign of the dividend (negated if signed and dividend negative).
  - Pulse `done_o`, go to IDLE.
- Divide by zero: `quotient_o` = all ones, `remainder_o` = original dividend (unmodified), `div_zero_o` = 1. The flag is cleared on the next non-zero-divisor completion.
- Signed overflow (0x80000000 / 0xFFFFFFFF): `quotient_o` = 0x80000000 (wraps), `remainder_o` = 0, `div_zero_o` = 0.
- Results and `div_zero_o` hold their value until the next `done_o`.
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtraction.

## Timing
- Reset (`rst_i`=0, asynchronous):
  - State goes to IDLE.
  - `busy_o`, `done_o`, `div_zero_o` = 0.
  - `quotient_o`, `remainder_o` = 0.
  - Counter = 0.
- Latency, edge 0 = the edge that samples `start_i`:
  - Non-zero divisor: `busy_o`=1 after edge 0; CALC occupies edges 1..WIDTH; FIX edge is WIDTH+1. After that edge, `done_o`=1 and `busy_o`=0. For WIDTH=32, `done_o` is high in the cycle after edge 33.
  - Zero divisor: after edge 0, `busy_o`=1. After edge 1, `done_o`=1 and `busy_o`=0.
- `done_o` is exactly one cycle wide.
- `start_i` while `busy_o`=1 is ignored, and the operand inputs may change freely.
- Back-to-back operation: `start_i` asserted in the same cycle as `done_o`=1 (state is IDLE) is accepted. The next operation begins with no bubble.
- Reset mid-operation aborts immediately: no `done_o` pulse, and outputs return to their reset values.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7 (`signed_i`=0), start at edge 0:
  - Required: `busy_o` high for edges 1..33.
  - Required: `done_o` pulse after edge 33 with `quotient_o`=14, `remainder_o`=2, `div_zero_o`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002): required `quotient_o`=0xFFFFFFFD, `remainder_o`=0xFFFFFFFF. Also signed 7 / −2: required `quotient_o`=0xFFFFFFFD, `remainder_o`=1.
- Divide by zero, 0x12345678 / 0:
  - Required: `done_o` after edge 1 with `quotient_o`=0xFFFFFFFF, `remainder_o`=0x12345678, `div_zero_o`=1.
  - Then 10 / 3 unsigned: required `div_zero_o` returns to 0, with q=3, r=1.
- Signed 0x80000000 / 0xFFFFFFFF: required `quotient_o`=0x80000000, `remainder_o`=0. Unsigned 0xFFFFFFFF / 1: required q=0xFFFFFFFF, r=0.
- Handshake:
  - Pulse `start_i` with different operands at edges 5 and 20 of a running op. Required: both ignored; results match the original operands.
  - Assert `start_i` in the `done_o` cycle. Required: the second result appears exactly 34 edges after the first `done_o`.
- Reset mid-op: assert `rst_i`=0 between clock edges at edge 15 of a divide. Required: `busy_o`, `done_o`, and the results are 0 immediately (before the next edge), and no `done_o` follows. After release, a new 9 / 3 gives q=3, r=0.
